bus_arbiter: RTL

- Shares the 68000 bus between the CPU and N_MASTERS auxiliary masters, such as a DMA engine or a debug loader.
- Requests the bus from the CPU with the BR/BG/BGACK handshake, then grants it to one master at a time using round-robin priority.
- Returns the bus to the CPU when the owner releases it.
- Sits beside the address decoder and DTACK generator. The granted master drives AS/UDS/LDS/ADDR through the same decode path.

---
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that borrows the 68000 bus from the CPU (BR/BG/BGACK) for N_MASTERS requesters.
// Define BUS_ARBITER_TIMEOUT_EN to add a tenure limit of MAX_HOLD cycles with a TIMEOUT pulse on revocation.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 256,
    parameter int HOLD_W    = 16
) (
    input  logic                 CPUCLK_IN,
    input  logic                 RUN_IN,
    input  logic [N_MASTERS-1:0] REQ_IN,
    input  logic                 BG_IN,
    input  logic                 AS_IN,
    input  logic                 DTACK_IN,
    output logic                 BR,
    output logic                 BGACK,
    output logic [N_MASTERS-1:0] GNT,
    output logic [2:0]           OWNER,
    output logic                 TIMEOUT,
    output logic [2:0]           DBG_STATE
);

    // Handshake: BR is held from REQUEST until the OWNED entry edge; BGACK covers OWNED and RELEASE;
    // GNT is one-hot only in OWNED, so a master may drive the bus exactly while its GNT bit is high.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_BUS = 3'd2,
        OWNED    = 3'd3,
        RELEASE  = 3'd4
    } state_e;

    state_e               state_q;
    logic                 br_q;
    logic                 bgack_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [2:0]           owner_q;
    logic [2:0]           last_q;

    logic [N_MASTERS-1:0] req_elig;
    logic                 any_req;
    logic                 owner_drop;
    logic [2:0]           win_idx;
    logic [N_MASTERS-1:0] win_onehot;
    int                   win_best;
    int                   win_dist;

    if (N_MASTERS < 1 || N_MASTERS > 8 || MAX_HOLD >= (1 << HOLD_W)) begin : g_bad_params
        $error("bus_arbiter: N_MASTERS must be 1..8 and 2**HOLD_W must exceed MAX_HOLD");
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0]    hold_q;
    logic [HOLD_W-1:0]    hold_d;
    logic [N_MASTERS-1:0] mask_q;
    logic                 timeout_q;
    logic                 revoke;

    // A revoked master stays masked until it has been seen low once.
    assign req_elig = REQ_IN & ~mask_q;
    assign hold_d   = (hold_q == HOLD_LIMIT) ? hold_q : hold_q + HOLD_W'(1);
    assign revoke   = (hold_d == HOLD_LIMIT) && ((req_elig & ~gnt_q) != '0);
    assign TIMEOUT  = timeout_q;
`else
    assign req_elig = REQ_IN;
    assign TIMEOUT  = 1'b0;
`endif

    assign any_req    = (req_elig != '0);
    assign owner_drop = ((REQ_IN & gnt_q) == '0);

    // Winner is the requester at the smallest circular distance past last_q.
    always_comb begin
        win_best   = N_MASTERS;
        win_dist   = 0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            win_dist = (i + 2 * N_MASTERS - 1 - int'(last_q)) % N_MASTERS;
            if (req_elig[i] && (win_dist < win_best)) begin
                win_best      = win_dist;
                win_idx       = 3'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            state_q   <= IDLE;
            br_q      <= 1'b0;
            bgack_q   <= 1'b0;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= 3'(N_MASTERS - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_q    <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
            mask_q    <= mask_q & REQ_IN;
`endif
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= REQUEST;
                        br_q    <= 1'b1;
                    end
                end
                REQUEST: begin
                    // Withdrawal beats a simultaneous BG_IN.
                    if (!any_req) begin
                        state_q <= IDLE;
                        br_q    <= 1'b0;
                    end else if (BG_IN) begin
                        state_q <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (!any_req) begin
                        state_q <= IDLE;
                        br_q    <= 1'b0;
                    end else if (!AS_IN && !DTACK_IN) begin
                        state_q <= OWNED;
                        br_q    <= 1'b0;
                        bgack_q <= 1'b1;
                        gnt_q   <= win_onehot;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                OWNED: begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                    hold_q <= hold_d;
`endif
                    if (owner_drop) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    else if (revoke) begin
                        state_q   <= RELEASE;
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                        mask_q    <= (mask_q & REQ_IN) | gnt_q;
                    end
`endif
                end
                RELEASE: begin
                    state_q <= IDLE;
                    bgack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    br_q    <= 1'b0;
                    bgack_q <= 1'b0;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign BR        = br_q;
    assign BGACK     = bgack_q;
    assign GNT       = gnt_q;
    assign OWNER     = owner_q;
    assign DBG_STATE = state_q;

endmodule
